// File: rtl/ffdiv_req_scheduler_if.sv
// Request/response bundle between the issue ports, the scheduler and the
// response consumer. The scheduler is the slave; issuers/consumer are master.
interface ffdiv_req_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_op_a;
    logic [NREQ*32-1:0] req_op_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_result;
    logic [4:0]         rsp_flags;
    logic               rsp_err;

    modport master (
        output req_valid, req_op_a, req_op_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );

    modport slave (
        input  req_valid, req_op_a, req_op_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );
endinterface

// File: rtl/ffdiv_req_scheduler.sv
// Round-robin scheduler sharing one ffdiv_32bit divider between NREQ
// requesters, with a watchdog that resets a hung divider and returns a
// forced NaN result flagged as an error.
module ffdiv_req_scheduler #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    ffdiv_req_scheduler_if.slave  bus,
    output logic                  div_en,
    output logic                  div_start,
    output logic [31:0]           div_op_a,
    output logic [31:0]           div_op_b,
    input  logic                  div_ready,
    input  logic [31:0]           div_result,
    input  logic [4:0]            div_flags,
    output logic                  div_rst_n,
    output logic                  busy
);
    localparam int WDW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ABORT} state_t;

    state_t          state, state_nx;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_vld;
    logic [WDW-1:0]  wd_cnt;
    logic            abort_q;
    logic            timeout;
    int              idx;

    assign timeout   = (wd_cnt == WDW'(TIMEOUT_CYC - 1));
    assign div_rst_n = ~(rst | abort_q);

    // Round-robin pick: scan downward so the last hit is the one closest to rr_ptr.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nx      = state;
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        div_en        = 1'b0;
        div_start     = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    if (!rst) bus.req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                div_en    = 1'b1;
                div_start = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                div_en = 1'b1;
                if (div_ready)    state_nx = RESP;
                else if (timeout) state_nx = ABORT;
            end
            ABORT: state_nx = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register, grant latching, watchdog and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            wd_cnt         <= '0;
            abort_q        <= 1'b0;
            div_op_a       <= '0;
            div_op_b       <= '0;
            bus.rsp_id     <= '0;
            bus.rsp_result <= '0;
            bus.rsp_flags  <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            state   <= state_nx;
            // One-cycle divider reset pulse covering the ABORT state.
            abort_q <= (state == WAIT) && !div_ready && timeout;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        div_op_a   <= bus.req_op_a[32*gnt_id +: 32];
                        div_op_b   <= bus.req_op_b[32*gnt_id +: 32];
                        bus.rsp_id <= gnt_id;
                        rr_ptr     <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    if (wd_cnt != {WDW{1'b1}}) wd_cnt <= wd_cnt + 1'b1;
                    if (div_ready) begin
                        bus.rsp_result <= div_result;
                        bus.rsp_flags  <= div_flags;
                        bus.rsp_err    <= 1'b0;
                    end else if (timeout) begin
                        bus.rsp_result <= 32'h7FC0_0000;
                        bus.rsp_flags  <= 5'b10000;
                        bus.rsp_err    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ffdiv_req_scheduler.sv
// Directed bench for ffdiv_req_scheduler. The bench plays the divider:
// it watches div_start and answers with hand-computed results.
module tb_ffdiv_req_scheduler;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_en, div_start, div_ready, div_rst_n, busy;
    logic [31:0] div_op_a, div_op_b, div_result;
    logic [4:0]  div_flags;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    ffdiv_req_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    ffdiv_req_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .div_en(div_en), .div_start(div_start), .div_op_a(div_op_a), .div_op_b(div_op_b),
        .div_ready(div_ready), .div_result(div_result), .div_flags(div_flags),
        .div_rst_n(div_rst_n), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid = '0; bus.req_op_a = '0; bus.req_op_b = '0; bus.rsp_ready = 1'b0;
        div_ready = 1'b0; div_result = '0; div_flags = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
        bus.req_op_a[32*id +: 32] = a;
        bus.req_op_b[32*id +: 32] = b;
    endtask

    // From the ISSUE cycle: hold div_ready low, raise it in the lat-th WAIT cycle.
    task automatic serve(input int lat, input logic [31:0] r, input logic [4:0] f);
        div_ready = 1'b0;
        tick();
        repeat (lat - 1) tick();
        div_ready = 1'b1; div_result = r; div_flags = f;
        tick();
        div_ready = 1'b0; div_result = '0; div_flags = '0;
        #1;
    endtask

    task automatic wait_grant(output int g, output bit ok);
        ok = 1'b0;
        g  = -1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.req_ready != '0) begin
                ok = 1'b1;
                for (int j = NREQ - 1; j >= 0; j--) if (bus.req_ready[j]) g = j;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (div_rst_n !== 1'b0) begin failures++; $display("FAIL reset_div_rst_n_during got=%0h exp=0", div_rst_n); end
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready_during got=%0h exp=0", bus.req_ready); end
        apply_reset();
        checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_valid_busy got=%0h/%0h exp=0/0", bus.rsp_valid, busy); end
        checks++; if ({bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err} !== '0) begin failures++; $display("FAIL reset_rsp_fields got=%0h/%0h/%0h/%0h exp=0", bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err); end
        checks++; if ({div_en, div_start, div_op_a, div_op_b} !== '0) begin failures++; $display("FAIL reset_div_outs got=%0h/%0h/%0h/%0h exp=0", div_en, div_start, div_op_a, div_op_b); end
        checks++; if (div_rst_n !== 1'b1) begin failures++; $display("FAIL reset_div_rst_n_after got=%0h exp=1", div_rst_n); end
    endtask

    task automatic test_single();
        apply_reset();
        set_op(0, 32'h4040_0000, 32'h4000_0000);
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%0h exp=1", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        #1;
        checks++; if (div_start !== 1'b1 || div_en !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_issue got=%0h/%0h/%0h exp=1/1/1", div_start, div_en, busy); end
        checks++; if (div_op_a !== 32'h4040_0000 || div_op_b !== 32'h4000_0000) begin failures++; $display("FAIL single_ops got=%h/%h exp=40400000/40000000", div_op_a, div_op_b); end
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_issue got=%0h exp=0", bus.req_ready); end
        serve(3, 32'h3FC0_0000, 5'b00000);
        checks++; if (bus.rsp_valid !== 1'b1 || div_en !== 1'b0) begin failures++; $display("FAIL single_resp_state got=%0h/%0h exp=1/0", bus.rsp_valid, div_en); end
        checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_result !== 32'h3FC0_0000 || bus.rsp_flags !== 5'b0 || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL single_rsp got=%0h/%h/%0h/%0h exp=0/3fc00000/0/0", bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%0h/%0h exp=0/0", bus.rsp_valid, busy); end
    endtask

    task automatic test_round_robin();
        int g;
        bit ok;
        int exp_id;
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'h4000_0000 + i, 32'h3F80_0000 + i);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            exp_id = n % NREQ;
            wait_grant(g, ok);
            checks++; if (!ok || g != exp_id || !$onehot(bus.req_ready)) begin failures++; $display("FAIL rr_grant%0d got=%0d ready=%0h exp=%0d", n, g, bus.req_ready, exp_id); end
            tick();
            #1;
            checks++; if (bus.req_ready !== 4'b0000 || div_op_a !== 32'h4000_0000 + exp_id) begin failures++; $display("FAIL rr_issue%0d got=%0h/%h exp=0/%h", n, bus.req_ready, div_op_a, 32'h4000_0000 + exp_id); end
            serve(2, 32'h1000_0000 + n, 5'b00001);
            checks++; if (bus.rsp_id !== 2'(exp_id) || bus.rsp_result !== 32'h1000_0000 + n) begin failures++; $display("FAIL rr_rsp%0d got=%0d/%h exp=%0d/%h", n, bus.rsp_id, bus.rsp_result, exp_id, 32'h1000_0000 + n); end
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        int g;
        bit ok;
        int bad;
        apply_reset();
        set_op(1, 32'h4120_0000, 32'h3F80_0000);
        set_op(2, 32'h4220_0000, 32'h4000_0000);
        bus.req_valid = 4'b0110;
        wait_grant(g, ok);
        checks++; if (!ok || g != 1) begin failures++; $display("FAIL bp_grant got=%0d exp=1", g); end
        tick();
        bus.req_valid = 4'b0100;
        serve(4, 32'h4120_0000, 5'b00010);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_result !== 32'h4120_0000 ||
                bus.rsp_flags !== 5'b00010 || bus.rsp_err !== 1'b0 || bus.req_ready !== 4'b0 || div_en !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_stable got=%0d bad cycles exp=0", bad); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0100 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_next_grant got=%0h/%0h exp=4/0", bus.req_ready, bus.rsp_valid); end
        tick();
        bus.req_valid = '0;
        #1;
        checks++; if (div_start !== 1'b1 || div_op_a !== 32'h4220_0000) begin failures++; $display("FAIL bp_next_issue got=%0h/%h exp=1/42200000", div_start, div_op_a); end
    endtask

    task automatic test_special();
        int g;
        bit ok;
        apply_reset();
        set_op(3, 32'h3F80_0000, 32'h0000_0000);
        bus.req_valid = 4'b1000;
        wait_grant(g, ok);
        checks++; if (!ok || g != 3) begin failures++; $display("FAIL sp_grant3 got=%0d exp=3", g); end
        tick();
        bus.req_valid = '0;
        serve(6, 32'h7F80_0000, 5'b00100);
        checks++; if (bus.rsp_id !== 2'd3 || bus.rsp_result !== 32'h7F80_0000 || bus.rsp_flags !== 5'b00100 || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL sp_div0 got=%0d/%h/%0h/%0h exp=3/7f800000/4/0", bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        set_op(0, 32'h0, 32'h0);
        bus.req_valid = 4'b0001;
        wait_grant(g, ok);
        checks++; if (!ok || g != 0) begin failures++; $display("FAIL sp_grant0 got=%0d exp=0", g); end
        tick();
        bus.req_valid = '0;
        serve(6, 32'h7FC0_0000, 5'b10000);
        checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_result !== 32'h7FC0_0000 || bus.rsp_flags !== 5'b10000 || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL sp_nan got=%0d/%h/%0h/%0h exp=0/7fc00000/10/0", bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    // div_ready lands in the same WAIT cycle the watchdog would fire.
    task automatic test_timeout_boundary();
        int g;
        bit ok;
        apply_reset();
        set_op(0, 32'h4080_0000, 32'h4080_0000);
        bus.req_valid = 4'b0001;
        wait_grant(g, ok);
        tick();
        bus.req_valid = '0;
        serve(TO, 32'h3F80_0000, 5'b00000);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_result !== 32'h3F80_0000 || div_rst_n !== 1'b1) begin failures++; $display("FAIL tb_coincide got=%0h/%0h/%h/%0h exp=1/0/3f800000/1", bus.rsp_valid, bus.rsp_err, bus.rsp_result, div_rst_n); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_hang();
        int g;
        bit ok;
        int n;
        apply_reset();
        set_op(0, 32'h4040_0000, 32'h4000_0000);
        bus.req_valid = 4'b0001;
        wait_grant(g, ok);
        tick();
        bus.req_valid = '0;
        div_ready = 1'b0;
        n = 0;
        tick();
        #1;
        while (div_rst_n === 1'b1 && n < 200) begin
            n++;
            tick();
            #1;
        end
        checks++; if (n != TO) begin failures++; $display("FAIL hang_wait_cycles got=%0d exp=%0d", n, TO); end
        checks++; if (div_rst_n !== 1'b0 || div_en !== 1'b0 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL hang_abort got=%0h/%0h/%0h exp=0/0/0", div_rst_n, div_en, bus.rsp_valid); end
        tick();
        #1;
        checks++; if (div_rst_n !== 1'b1 || bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL hang_resp_state got=%0h/%0h exp=1/1", div_rst_n, bus.rsp_valid); end
        checks++; if (bus.rsp_result !== 32'h7FC0_0000 || bus.rsp_flags !== 5'b10000 || bus.rsp_err !== 1'b1) begin failures++; $display("FAIL hang_rsp got=%h/%0h/%0h exp=7fc00000/10/1", bus.rsp_result, bus.rsp_flags, bus.rsp_err); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int g;
        bit ok;
        int bad;
        apply_reset();
        set_op(2, 32'h4040_0000, 32'h4000_0000);
        bus.req_valid = 4'b0100;
        wait_grant(g, ok);
        checks++; if (!ok || g != 2) begin failures++; $display("FAIL rmw_grant got=%0d exp=2", g); end
        tick();
        bus.req_valid = '0;
        div_ready = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        checks++; if (div_rst_n !== 1'b0) begin failures++; $display("FAIL rmw_div_rst_n got=%0h exp=0", div_rst_n); end
        tick();
        #1;
        checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.req_ready} !== '0) begin failures++; $display("FAIL rmw_rsp_zero got=%0h/%0h/%h/%0h/%0h/%0h exp=0", bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.req_ready); end
        checks++; if ({div_en, div_start, div_op_a, div_op_b, busy} !== '0) begin failures++; $display("FAIL rmw_div_zero got=%0h/%0h/%h/%h/%0h exp=0", div_en, div_start, div_op_a, div_op_b, busy); end
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            #1;
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || div_rst_n !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rmw_no_stale got=%0d bad cycles exp=0", bad); end
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rmw_rr_ptr got=%0h exp=1", bus.req_ready); end
        bus.req_valid = '0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0; bus.req_op_a = '0; bus.req_op_b = '0; bus.rsp_ready = 1'b0;
        div_ready = 1'b0; div_result = '0; div_flags = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_special();
        test_timeout_boundary();
        test_hang();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
